uart_cmd_parser: RTL and testbench

Downstream consumer of the UART receiver's byte strobe (fifo_wr/fifo_data pair). Parses ASCII hex command lines into single-cycle register-bus write/read requests for on-chip control registers (e.g. measurement config).
- Write line: "W" + address + data + CR/LF.
- Read line: "R" + address + CR/LF.
- Malformed lines raise an error pulse and resynchronise to idle.

---
 rtl/uart_cmd_parser.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// ASCII hex command-line parser: "W<addr><data>CR/LF" and "R<addr>CR/LF" become one-cycle register-bus requests.
// Optional terminal echo of every received byte is enabled by defining UART_CMD_ECHO_EN.
module uart_cmd_parser #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1600000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              byte_wr_i,
    input  logic [7:0]        byte_data_i,
    output logic              reg_we_o,
    output logic              reg_re_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              err_o,
    output logic              busy_o,
    output logic              echo_wr_o,
    output logic [7:0]        echo_data_o
);

    localparam int ADDR_DIG = ADDR_W / 4;
    localparam int DATA_DIG = DATA_W / 4;
    localparam int MAX_DIG  = (ADDR_DIG > DATA_DIG) ? ADDR_DIG : DATA_DIG;
    localparam int CNT_W    = $clog2(MAX_DIG + 1);
    localparam int TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit TMO_EN   = (TIMEOUT_CYC > 0);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_DIG - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_DIG - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_EOL   = 3'd3,
        ST_ISSUE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0]   addr_acc_q, addr_acc_d;
    logic [DATA_W-1:0]   data_acc_q, data_acc_d;
    logic [CNT_W-1:0]    dig_cnt_q, dig_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                reg_we_q, reg_we_d;
    logic                reg_re_q, reg_re_d;
    logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
    logic                err_q, err_d;

    logic                byte_s;
    logic                is_eol_s;
    logic                is_wcmd_s;
    logic                is_rcmd_s;
    logic                in_line_s;
    logic                tmo_expire_s;
    logic [4:0]          hex_s;

    // Returns {valid, nibble} for an ASCII hex digit of either case.
    function automatic logic [4:0] hex_decode(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) begin
            return {1'b1, b[3:0]};
        end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
            return {1'b1, b[3:0] + 4'd9};
        end else begin
            return 5'd0;
        end
    endfunction

    // Spaces are never significant, so they are filtered out of the byte strobe here.
    assign byte_s       = byte_wr_i && (byte_data_i != 8'h20);
    assign is_eol_s     = (byte_data_i == 8'h0D) || (byte_data_i == 8'h0A);
    assign is_wcmd_s    = (byte_data_i == 8'h57) || (byte_data_i == 8'h77);
    assign is_rcmd_s    = (byte_data_i == 8'h52) || (byte_data_i == 8'h72);
    assign hex_s        = hex_decode(byte_data_i);
    assign in_line_s    = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_EOL);
    assign tmo_expire_s = TMO_EN && in_line_s && !byte_wr_i && (tmo_cnt_q == TMO_LAST);

    // Next-state, accumulator, timeout and request decode.
    always_comb begin
        state_d     = state_q;
        cmd_wr_d    = cmd_wr_q;
        addr_acc_d  = addr_acc_q;
        data_acc_d  = data_acc_q;
        dig_cnt_d   = dig_cnt_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        err_d       = 1'b0;

        if (byte_wr_i || !in_line_s || !TMO_EN) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end

        case (state_q)
            // ISSUE lasts one cycle; a byte arriving in it follows the IDLE rules.
            ST_IDLE, ST_ISSUE: begin
                state_d = ST_IDLE;
                if (byte_s) begin
                    if (is_wcmd_s || is_rcmd_s) begin
                        state_d    = ST_ADDR;
                        cmd_wr_d   = is_wcmd_s;
                        addr_acc_d = '0;
                        data_acc_d = '0;
                        dig_cnt_d  = '0;
                    end else if (is_eol_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (byte_s) begin
                    if (hex_s[4]) begin
                        addr_acc_d = (addr_acc_q << 4) | ADDR_W'(hex_s[3:0]);
                        if (dig_cnt_q == ADDR_LAST) begin
                            dig_cnt_d = '0;
                            state_d   = cmd_wr_q ? ST_DATA : ST_EOL;
                        end else begin
                            dig_cnt_d = dig_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (byte_s) begin
                    if (hex_s[4]) begin
                        data_acc_d = (data_acc_q << 4) | DATA_W'(hex_s[3:0]);
                        if (dig_cnt_q == DATA_LAST) begin
                            dig_cnt_d = '0;
                            state_d   = ST_EOL;
                        end else begin
                            dig_cnt_d = dig_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_EOL: begin
                if (byte_s) begin
                    if (is_eol_s) begin
                        state_d    = ST_ISSUE;
                        reg_addr_d = addr_acc_q;
                        if (cmd_wr_q) begin
                            reg_wdata_d = data_acc_q;
                            reg_we_d    = 1'b1;
                        end else begin
                            reg_re_d = 1'b1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_EOL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Expiry can only occur in a cycle without a byte, so it never races a decode above.
        if (tmo_expire_s) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end else begin
            err_d = err_d;
        end
    end

    // State, accumulators and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cmd_wr_q    <= 1'b0;
            addr_acc_q  <= '0;
            data_acc_q  <= '0;
            dig_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_wr_q    <= cmd_wr_d;
            addr_acc_q  <= addr_acc_d;
            data_acc_q  <= data_acc_d;
            dig_cnt_q   <= dig_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            err_q       <= err_d;
        end
    end

    assign reg_we_o    = reg_we_q;
    assign reg_re_o    = reg_re_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign err_o       = err_q;
    assign busy_o      = (state_q != ST_IDLE);

`ifdef UART_CMD_ECHO_EN
    logic       echo_wr_q;
    logic [7:0] echo_data_q;

    // Echo register: every strobed byte is replayed one cycle later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            echo_wr_q   <= 1'b0;
            echo_data_q <= 8'h00;
        end else begin
            echo_wr_q <= byte_wr_i;
            if (byte_wr_i) begin
                echo_data_q <= byte_data_i;
            end
        end
    end

    assign echo_wr_o   = echo_wr_q;
    assign echo_data_o = echo_data_q;
`else
    assign echo_wr_o   = 1'b0;
    assign echo_data_o = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed scenarios plus randomized lines
// compared cycle by cycle against a line-buffer reference model.
module tb_uart_cmd_parser;

    localparam int TMO = 100;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       byte_wr_i = 1'b0;
    logic [7:0] byte_data_i = 8'h00;
    logic       reg_we_o;
    logic       reg_re_o;
    logic [7:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       err_o;
    logic       busy_o;
    logic       echo_wr_o;
    logic [7:0] echo_data_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: the non-space characters of the line in progress.
    logic [7:0] line_q[$];
    int         idle_cnt;
    logic       exp_we, exp_re, exp_err, exp_busy, exp_echo_wr;
    logic [7:0] exp_addr, exp_wdata, exp_echo_data;

    int we_seen, re_seen, err_seen, echo_seen;

    typedef struct packed {
        logic       wr;
        logic [7:0] b;
        logic       rst;
    } ev_t;
    ev_t ev_q[$];

    uart_cmd_parser #(
        .ADDR_W      (8),
        .DATA_W      (8),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .byte_wr_i   (byte_wr_i),
        .byte_data_i (byte_data_i),
        .reg_we_o    (reg_we_o),
        .reg_re_o    (reg_re_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .echo_wr_o   (echo_wr_o),
        .echo_data_o (echo_data_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int hexval(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        else if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        else if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        else return -1;
    endfunction

    function automatic bit is_term(input logic [7:0] c);
        return (c == 8'h0D) || (c == 8'h0A);
    endfunction

    // Expected outputs after one clock, derived from the line text seen so far.
    task automatic model_update(input logic wr, input logic [7:0] b, input logic rst);
        bit issued = 1'b0;
        int need;
        exp_we  = 1'b0;
        exp_re  = 1'b0;
        exp_err = 1'b0;
        if (rst) begin
            line_q.delete();
            idle_cnt      = 0;
            exp_addr      = 8'h00;
            exp_wdata     = 8'h00;
            exp_busy      = 1'b0;
            exp_echo_wr   = 1'b0;
            exp_echo_data = 8'h00;
            return;
        end
`ifdef UART_CMD_ECHO_EN
        exp_echo_wr = wr;
        if (wr) exp_echo_data = b;
`endif
        if (wr) begin
            idle_cnt = 0;
            if (b != 8'h20) begin
                if (line_q.size() == 0) begin
                    if (b inside {8'h57, 8'h77, 8'h52, 8'h72}) line_q.push_back(b);
                    else if (!is_term(b)) exp_err = 1'b1;
                end else begin
                    need = (line_q[0] inside {8'h57, 8'h77}) ? 4 : 2;
                    if (line_q.size() < need + 1) begin
                        if (hexval(b) >= 0) line_q.push_back(b);
                        else begin exp_err = 1'b1; line_q.delete(); end
                    end else if (is_term(b)) begin
                        exp_addr = 8'(hexval(line_q[1]) * 16 + hexval(line_q[2]));
                        if (need == 4) begin
                            exp_wdata = 8'(hexval(line_q[3]) * 16 + hexval(line_q[4]));
                            exp_we    = 1'b1;
                        end else begin
                            exp_re = 1'b1;
                        end
                        line_q.delete();
                        issued = 1'b1;
                    end else begin
                        exp_err = 1'b1;
                        line_q.delete();
                    end
                end
            end
        end else if (line_q.size() != 0) begin
            idle_cnt++;
            if (idle_cnt == TMO) begin
                exp_err = 1'b1;
                line_q.delete();
                idle_cnt = 0;
            end
        end
        exp_busy = (line_q.size() != 0) || issued;
    endtask

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic wr, input logic [7:0] b, input logic rst);
        rst_i       = rst;
        byte_wr_i   = wr;
        byte_data_i = b;
        @(posedge clk_i);
        #1;
        model_update(wr, b, rst);
        if (reg_we_o === 1'b1) we_seen++;
        if (reg_re_o === 1'b1) re_seen++;
        if (err_o === 1'b1) err_seen++;
        if (echo_wr_o === 1'b1) echo_seen++;
        rst_i     = 1'b0;
        byte_wr_i = 1'b0;
    endtask

    task automatic send(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            step(1'b1, s[i], 1'b0);
            repeat (gap) step(1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic clear_seen();
        we_seen = 0; re_seen = 0; err_seen = 0; echo_seen = 0;
    endtask

    task automatic test_reset();
        step(1'b0, 8'h00, 1'b1);
        n_checks += 6;
        if (reg_we_o !== 1'b0) $display("FAIL reset_we got %b want 0", reg_we_o); else n_pass++;
        if (reg_re_o !== 1'b0) $display("FAIL reset_re got %b want 0", reg_re_o); else n_pass++;
        if (err_o !== 1'b0) $display("FAIL reset_err got %b want 0", err_o); else n_pass++;
        if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else n_pass++;
        if ({reg_addr_o, reg_wdata_o} !== 16'h0000) $display("FAIL reset_addr_data got %h want 0000", {reg_addr_o, reg_wdata_o}); else n_pass++;
        if ({echo_wr_o, echo_data_o} !== 9'h000) $display("FAIL reset_echo got %h want 000", {echo_wr_o, echo_data_o}); else n_pass++;
    endtask

    task automatic test_write();
        clear_seen();
        send("W3A5c", 60);
        step(1'b1, 8'h0D, 1'b0);
        n_checks += 4;
        if (reg_we_o !== 1'b1) $display("FAIL write_we_latency got %b want 1", reg_we_o); else n_pass++;
        if (reg_addr_o !== 8'h3A) $display("FAIL write_addr got %h want 3a", reg_addr_o); else n_pass++;
        if (reg_wdata_o !== 8'h5C) $display("FAIL write_data got %h want 5c", reg_wdata_o); else n_pass++;
        if (reg_re_o !== 1'b0) $display("FAIL write_re got %b want 0", reg_re_o); else n_pass++;
        step(1'b0, 8'h00, 1'b0);
        n_checks += 4;
        if (reg_we_o !== 1'b0) $display("FAIL write_we_width got %b want 0", reg_we_o); else n_pass++;
        if (busy_o !== 1'b0) $display("FAIL write_busy_after got %b want 0", busy_o); else n_pass++;
        if (we_seen !== 1) $display("FAIL write_we_count got %0d want 1", we_seen); else n_pass++;
        if (err_seen !== 0) $display("FAIL write_err_count got %0d want 0", err_seen); else n_pass++;
    endtask

    task automatic test_read();
        clear_seen();
        send("rFF", 3);
        step(1'b1, 8'h0D, 1'b0);
        n_checks += 3;
        if (reg_re_o !== 1'b1) $display("FAIL read_re got %b want 1", reg_re_o); else n_pass++;
        if (reg_addr_o !== 8'hFF) $display("FAIL read_addr got %h want ff", reg_addr_o); else n_pass++;
        if (reg_wdata_o !== 8'h5C) $display("FAIL read_wdata_held got %h want 5c", reg_wdata_o); else n_pass++;
        step(1'b1, 8'h0A, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        n_checks += 3;
        if (err_seen !== 0) $display("FAIL read_lf_err got %0d want 0", err_seen); else n_pass++;
        if (re_seen !== 1) $display("FAIL read_re_count got %0d want 1", re_seen); else n_pass++;
        if (we_seen !== 0) $display("FAIL read_we_count got %0d want 0", we_seen); else n_pass++;
    endtask

    task automatic test_bad_digit();
        clear_seen();
        send("W1", 2);
        step(1'b1, 8'h47, 1'b0);
        n_checks += 2;
        if (err_o !== 1'b1) $display("FAIL bad_digit_err got %b want 1", err_o); else n_pass++;
        if (busy_o !== 1'b0) $display("FAIL bad_digit_idle got %b want 0", busy_o); else n_pass++;
        send("W0102\r", 1);
        n_checks += 3;
        if (we_seen !== 1) $display("FAIL bad_digit_recover_we got %0d want 1", we_seen); else n_pass++;
        if ({reg_addr_o, reg_wdata_o} !== 16'h0102) $display("FAIL bad_digit_recover got %h want 0102", {reg_addr_o, reg_wdata_o}); else n_pass++;
        if (err_seen !== 1) $display("FAIL bad_digit_err_count got %0d want 1", err_seen); else n_pass++;
    endtask

    task automatic test_timeout();
        int first_err;
        logic busy_before;
        clear_seen();
        first_err = -1;
        busy_before = 1'b0;
        send("W1", 0);
        for (int k = 1; k <= TMO + 5; k++) begin
            step(1'b0, 8'h00, 1'b0);
            if (k == TMO - 1) busy_before = busy_o;
            if (err_o === 1'b1 && first_err < 0) first_err = k;
        end
        n_checks += 3;
        if (first_err !== TMO) $display("FAIL timeout_latency got %0d want %0d", first_err, TMO); else n_pass++;
        if (busy_before !== 1'b1) $display("FAIL timeout_busy_before got %b want 1", busy_before); else n_pass++;
        if (busy_o !== 1'b0) $display("FAIL timeout_busy_after got %b want 0", busy_o); else n_pass++;
        clear_seen();
        send("W1", 0);
        repeat (TMO - 1) step(1'b0, 8'h00, 1'b0);
        send("234\r", 0);
        step(1'b0, 8'h00, 1'b0);
        n_checks += 3;
        if (err_seen !== 0) $display("FAIL timeout_byte_wins_err got %0d want 0", err_seen); else n_pass++;
        if (we_seen !== 1) $display("FAIL timeout_byte_wins_we got %0d want 1", we_seen); else n_pass++;
        if ({reg_addr_o, reg_wdata_o} !== 16'h1234) $display("FAIL timeout_byte_wins_val got %h want 1234", {reg_addr_o, reg_wdata_o}); else n_pass++;
    endtask

    task automatic test_reset_midline();
        clear_seen();
        send("W12", 1);
        step(1'b0, 8'h00, 1'b1);
        n_checks += 2;
        if ({reg_addr_o, reg_wdata_o} !== 16'h0000) $display("FAIL midreset_regs got %h want 0000", {reg_addr_o, reg_wdata_o}); else n_pass++;
        if (busy_o !== 1'b0) $display("FAIL midreset_busy got %b want 0", busy_o); else n_pass++;
        step(1'b1, 8'h33, 1'b0);
        n_checks += 1;
        if (err_o !== 1'b1) $display("FAIL midreset_idle_err got %b want 1", err_o); else n_pass++;
        send("4\r", 1);
        n_checks += 1;
        if (we_seen !== 0) $display("FAIL midreset_no_write got %0d want 0", we_seen); else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_seen();
        send("W1122\rR33\r\n", 0);
        step(1'b0, 8'h00, 1'b0);
        n_checks += 4;
        if (we_seen !== 1 || re_seen !== 1) $display("FAIL b2b_counts got we=%0d re=%0d want 1 1", we_seen, re_seen); else n_pass++;
        if (reg_addr_o !== 8'h33) $display("FAIL b2b_addr got %h want 33", reg_addr_o); else n_pass++;
        if (reg_wdata_o !== 8'h22) $display("FAIL b2b_data got %h want 22", reg_wdata_o); else n_pass++;
        if (err_seen !== 0) $display("FAIL b2b_err got %0d want 0", err_seen); else n_pass++;
    endtask

    task automatic test_echo();
        string s = "W3A5c\r";
        int    exp_pulses;
        logic [7:0] want;
        clear_seen();
        for (int i = 0; i < s.len(); i++) begin
            step(1'b1, s[i], 1'b0);
            want = s[i];
`ifdef UART_CMD_ECHO_EN
            n_checks++;
            if ({echo_wr_o, echo_data_o} !== {1'b1, want}) $display("FAIL echo_byte%0d got %h want %h", i, {echo_wr_o, echo_data_o}, {1'b1, want}); else n_pass++;
`else
            n_checks++;
            if ({echo_wr_o, echo_data_o} !== 9'h000) $display("FAIL echo_off%0d got %h want 000 (byte %h)", i, {echo_wr_o, echo_data_o}, want); else n_pass++;
`endif
        end
        step(1'b0, 8'h00, 1'b0);
`ifdef UART_CMD_ECHO_EN
        exp_pulses = 6;
`else
        exp_pulses = 0;
`endif
        n_checks++;
        if (echo_seen !== exp_pulses) $display("FAIL echo_count got %0d want %0d", echo_seen, exp_pulses); else n_pass++;
    endtask

    task automatic test_random();
        string cmds  = "WwRr";
        string hexs  = "0123456789abcdefABCDEF";
        string junk  = "GgxZ:/.q";
        logic [7:0] ln[$];
        int kind, nd, gap;
        logic [7:0] c;
        ev_q.delete();
        for (int n = 0; n < 160; n++) begin
            ln.delete();
            kind = $urandom_range(0, 11);
            c = cmds[$urandom_range(0, 3)];
            nd = (c inside {8'h57, 8'h77}) ? 4 : 2;
            ln.push_back(c);
            for (int d = 0; d < nd; d++) ln.push_back(hexs[$urandom_range(0, 21)]);
            case ($urandom_range(0, 2))
                0: ln.push_back(8'h0D);
                1: ln.push_back(8'h0A);
                default: begin ln.push_back(8'h0D); ln.push_back(8'h0A); end
            endcase
            if (kind == 0) ln[$urandom_range(0, nd + 1)] = junk[$urandom_range(0, junk.len() - 1)];
            if (kind == 1) ln.insert(nd + 1, hexs[$urandom_range(0, 21)]);
            if (kind == 4) ln.push_front(junk[$urandom_range(0, junk.len() - 1)]);
            for (int i = 0; i < ln.size(); i++) begin
                if ($urandom_range(0, 7) == 0) ev_q.push_back('{1'b1, 8'h20, 1'b0});
                ev_q.push_back('{1'b1, ln[i], 1'b0});
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) ev_q.push_back('{1'b0, 8'h00, 1'b0});
                if (kind == 2 && i == 1) for (int g = 0; g < TMO + 1; g++) ev_q.push_back('{1'b0, 8'h00, 1'b0});
                if (kind == 3 && i == 2) ev_q.push_back('{1'b0, 8'h00, 1'b1});
            end
        end
        foreach (ev_q[i]) begin
            step(ev_q[i].wr, ev_q[i].b, ev_q[i].rst);
            n_checks += 7;
            if (reg_we_o !== exp_we) $display("FAIL rand_we ev%0d got %b want %b", i, reg_we_o, exp_we); else n_pass++;
            if (reg_re_o !== exp_re) $display("FAIL rand_re ev%0d got %b want %b", i, reg_re_o, exp_re); else n_pass++;
            if (err_o !== exp_err) $display("FAIL rand_err ev%0d got %b want %b", i, err_o, exp_err); else n_pass++;
            if (busy_o !== exp_busy) $display("FAIL rand_busy ev%0d got %b want %b", i, busy_o, exp_busy); else n_pass++;
            if (reg_addr_o !== exp_addr) $display("FAIL rand_addr ev%0d got %h want %h", i, reg_addr_o, exp_addr); else n_pass++;
            if (reg_wdata_o !== exp_wdata) $display("FAIL rand_wdata ev%0d got %h want %h", i, reg_wdata_o, exp_wdata); else n_pass++;
            if ({echo_wr_o, echo_data_o} !== {exp_echo_wr, exp_echo_data}) $display("FAIL rand_echo ev%0d got %h want %h", i, {echo_wr_o, echo_data_o}, {exp_echo_wr, exp_echo_data}); else n_pass++;
        end
    endtask

    initial begin
        idle_cnt = 0;
        clear_seen();
        test_reset();
        test_write();
        test_read();
        test_bad_digit();
        test_timeout();
        test_reset_midline();
        test_back_to_back();
        test_echo();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
